// File: rtl/fetch_unit_pkg.sv
// Shared RISC-V constants (riscv_pkg) plus fetch-stage types and helpers (fetch_unit_pkg).
// riscv_pkg is listed first because fetch_unit_pkg builds on it.
package riscv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
endpackage

package fetch_unit_pkg;
  import riscv_pkg::*;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response bus and the core-side
// instruction/redirect handshake. The fetch unit is the master; memory and core are the slave.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// The head reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises sticky fetch_err and halts fetch.
module fetch_unit
  import riscv_pkg::*;
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int          EW         = $bits(fetch_entry_t);
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic            w_err;
  logic            w_grant;
  logic            w_rsp;
  logic            w_drop;
  logic            w_keep;
  logic            w_pend_pop;
  logic            w_pop;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_inst_count;
  logic [CW:0]     w_inflight;
  logic            w_inst_empty;
  logic [XLEN-1:0] w_pend_pc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  logic            w_unused_inst_full;
  logic            w_unused_pend_full;
  logic            w_unused_pend_empty;
  logic [CW-1:0]   w_unused_pend_count;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fetch_err;
  logic w_misalign;

  assign w_misalign = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset)           r_fetch_err <= 1'b0;
    else if (w_misalign) r_fetch_err <= 1'b1;
  end

  assign w_err = r_fetch_err;
`else
  assign w_err = 1'b0;
`endif

  assign bus.fetch_err = w_err;

  // Buffered plus in-flight never exceeds the FIFO depth, so a response always has a slot.
  assign w_inflight   = {1'b0, w_inst_count} + {1'b0, r_outstanding};
  assign bus.imem_req = !reset && !w_err && !bus.redirect_valid && (w_inflight < CREDIT_MAX);
  assign bus.imem_addr = r_fetch_pc;

  assign w_grant = bus.imem_req && bus.imem_gnt;
  // Responses with nothing outstanding (e.g. stragglers after a reset) are ignored.
  assign w_rsp      = bus.imem_rvalid && (r_outstanding != '0);
  assign w_drop     = w_rsp && (r_discard != '0);
  assign w_pend_pop = w_rsp && !w_drop;
  assign w_keep     = w_pend_pop && !bus.redirect_valid;
  assign w_pop      = bus.inst_valid && bus.inst_ready;

  assign w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_rsp);

  assign w_push_entry = '{pc: w_pend_pc, inst: bus.imem_rdata};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_data  (w_head),
    .o_count (w_inst_count),
    .o_empty (w_inst_empty),
    .o_full  (w_unused_inst_full)
  );

  // In-order record of the address behind every live request.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_grant),
    .i_data  (r_fetch_pc),
    .i_pop   (w_pend_pop),
    .i_flush (bus.redirect_valid),
    .o_data  (w_pend_pc),
    .o_count (w_unused_pend_count),
    .o_empty (w_unused_pend_empty),
    .o_full  (w_unused_pend_full)
  );

  assign bus.inst_valid = !w_inst_empty && !w_err;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= align_pc(RESET_PC);
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= align_pc(bus.redirect_pc);
        r_discard  <= w_outstanding_nxt;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + PC_INC;
        if (w_drop)  r_discard  <= r_discard - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against
// a stream-level model (request stream, epoch-tagged memory queue, expected delivery queue).
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          gnt_pct  = 100;
  int          rdy_pct  = 100;
  int          first_valid = 0;
  int          n_dut_pops  = 0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_req_pc = RST_PC;
  logic        redir_now = 1'b0;
  logic [31:0] redir_pc_now = 32'h0;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] gaddr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_imem_req", bus.imem_req, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, RST_PC);
      chk("rst_inst_valid", bus.inst_valid, 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      chk("rst_fetch_err", bus.fetch_err, 32'd0);
    end
    reset = 1'b0;
    mq.delete();
    exp_q.delete();
    popped.delete();
    gaddr.delete();
    exp_req_pc  = RST_PC;
    exp_err     = 1'b0;
    epoch++;
    cyc         = 1;
    first_valid = 0;
    n_dut_pops  = 0;
    redir_now   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the model, advance the model.
  task automatic do_cycle();
    logic  rv, exp_req, g, p;
    mreq_t r;
    int    due;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem_word(mq[0].addr) : $urandom;
    bus.imem_gnt       = ($urandom_range(99) < gnt_pct);
    bus.inst_ready     = ($urandom_range(99) < rdy_pct);
    bus.redirect_valid = redir_now;
    bus.redirect_pc    = redir_now ? redir_pc_now : $urandom;
    #1;
    exp_req = !redir_now && !exp_err && ((exp_q.size() + mq.size()) < DEPTH);
    chk("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, exp_req_pc);
    chk("inst_valid", bus.inst_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("inst_pc", bus.inst_pc, exp_q[0]);
      chk("inst", bus.inst, mem_word(exp_q[0]));
    end
    chk("fetch_err", bus.fetch_err, exp_err);

    if (bus.inst_valid === 1'b1 && first_valid == 0) first_valid = cyc;
    if (bus.inst_valid === 1'b1 && bus.inst_ready) begin
      n_dut_pops++;
      popped.push_back(bus.inst_pc);
    end
    if (bus.imem_req === 1'b1 && bus.imem_gnt) gaddr.push_back(bus.imem_addr);

    g = exp_req && bus.imem_gnt;
    p = (exp_q.size() > 0) && bus.inst_ready;
    if (p) void'(exp_q.pop_front());
    if (rv) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !redir_now && !exp_err) exp_q.push_back(r.addr);
    end
    if (g) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mq.size() > 0 && due <= mq[mq.size()-1].due) due = mq[mq.size()-1].due + 1;
      mq.push_back('{addr: exp_req_pc, due: due, epoch: epoch});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (redir_now) begin
      exp_q.delete();
      epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redir_pc_now[1:0] != 2'b00) exp_err = 1'b1;
`endif
      exp_req_pc = {redir_pc_now[31:2], 2'b00};
    end
    redir_now = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir_now    = 1'b1;
    redir_pc_now = pc;
    do_cycle();
  endtask

  initial begin
    logic [31:0] pc;

    // Reset and streaming with 1-cycle memory, core always ready.
    do_reset(3);
    lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
    repeat (20) do_cycle();
    chk("thru_first_valid_cycle", first_valid, 32'd3);
    chk("thru_pops_in_20", n_dut_pops, 32'd18);
    chk("thru_first_req_addr", gaddr.size() > 0 ? gaddr[0] : 32'hDEAD_BEEF, RST_PC);

    // Core stalled: exactly DEPTH grants, head holds PC 0.
    do_reset(1);
    rdy_pct = 0;
    repeat (12) do_cycle();
    chk("stall_grants", gaddr.size(), DEPTH);
    chk("stall_head_pc", bus.inst_pc, 32'h0);
    chk("stall_req_low", bus.imem_req, 32'd0);
    rdy_pct = 100;
    repeat (10) do_cycle();

    // 3-cycle memory, redirect with two requests outstanding.
    do_reset(1);
    lat_min = 3; lat_max = 3;
    repeat (2) do_cycle();
    popped.delete();
    redirect_to(32'h0000_0100);
    chk("redir_discard_cnt", dut.r_discard, 32'd2);
    repeat (12) do_cycle();
    chk("redir_first_pc", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect coinciding with pop and rvalid, then drain to idle.
    do_reset(1);
    lat_min = 2; lat_max = 2;
    repeat (6) do_cycle();
    redirect_to(32'h0000_0200);
    gnt_pct = 0;
    repeat (8) do_cycle();
    chk("idle_outstanding", dut.r_outstanding, 32'd0);
    chk("idle_discard", dut.r_discard, 32'd0);
    chk("idle_inst_valid", bus.inst_valid, 32'd0);

    // PC wrap at the top of the address space.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    gaddr.delete();
    redirect_to(32'hFFFF_FFFC);
    repeat (6) do_cycle();
    chk("wrap_addr0", gaddr.size() > 0 ? gaddr[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_addr1", gaddr.size() > 1 ? gaddr[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Misaligned redirect.
    gaddr.delete();
    redirect_to(32'h0000_0102);
    repeat (8) do_cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_err", bus.fetch_err, 32'd1);
    chk("misalign_no_grant", gaddr.size(), 32'd0);
    chk("misalign_no_valid", bus.inst_valid, 32'd0);
`else
    chk("misalign_addr", gaddr.size() > 0 ? gaddr[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    chk("misalign_err_tied", bus.fetch_err, 32'd0);
`endif

    // Randomized traffic with redirects and a mid-run reset.
    do_reset(2);
    lat_min = 1; lat_max = 4; gnt_pct = 70; rdy_pct = 60;
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset(1);
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0:       pc = $urandom & 32'hFFFF_FFFC;
          1:       pc = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
          2:       pc = 32'h0000_1000 + ($urandom_range(63) << 2);
`ifdef FETCH_MISALIGN_CHECK_EN
          default: pc = 32'h0000_2000 + ($urandom_range(15) << 2);
`else
          default: pc = $urandom;
`endif
        endcase
        redir_now    = 1'b1;
        redir_pc_now = pc;
      end
      do_cycle();
    end
    rdy_pct = 100; gnt_pct = 0;
    repeat (12) do_cycle();
    chk("final_outstanding", dut.r_outstanding, 32'd0);
    chk("final_inst_valid", bus.inst_valid, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
